servo_slew_driver: RTL and testbench

- Downstream consumer of the sweep/peak-search block's base and arm angle outputs.
- Latches target angles on a load strobe and moves each servo's current angle one degree at a time, at a fixed slew rate, toward its target.
- Generates standard hobby-servo PWM frames for both motors and reports when both have reached their targets.
- Sits between the angle search and the physical base/arm servos.

---
 rtl/servo_slew_driver.sv | 138 +++++++++++++
 tb/tb_servo_slew_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_driver.sv
// Dual hobby-servo driver: latches clamped target angles, slews each axis one degree
// per STEP_FRAMES PWM frames, and emits one pulse per frame on each servo output.
module servo_slew_driver #(
  parameter int TICKS_PER_US = 50,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 500,
  parameter int US_PER_DEG   = 11,
  parameter int STEP_FRAMES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tgt_base,
  input  logic [7:0] tgt_arm,
  output logic       pwm_base,
  output logic       pwm_arm,
  output logic [7:0] cur_base,
  output logic [7:0] cur_arm,
  output logic       settled
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_US - 1);
  localparam logic [15:0]   FRAME_LAST = 16'(PERIOD_US - 1);
  localparam logic [SW-1:0] SCNT_LAST  = SW'(STEP_FRAMES - 1);
  localparam logic [7:0]    MAX_DEG    = 8'd180;

  typedef enum logic {IDLE, SLEW} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [15:0]   fcnt;
  logic [15:0]   width_base, width_arm;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [7:0]    tgt_base_q, tgt_arm_q, tgt_base_d, tgt_arm_d;
  logic [7:0]    cur_base_d, cur_arm_d;
  logic          us_tick, frame_start, step_now;

  function automatic logic [7:0] clamp_deg(input logic [7:0] deg);
    return (deg > MAX_DEG) ? MAX_DEG : deg;
  endfunction

  function automatic logic [7:0] toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] nxt;
    nxt = cur;
    if (cur < tgt) nxt = cur + 8'd1;
    else if (cur > tgt) nxt = cur - 8'd1;
    return nxt;
  endfunction

  function automatic logic [15:0] width_of(input logic [7:0] deg);
    return 16'(MIN_US) + 16'(deg) * 16'(US_PER_DEG);
  endfunction

  assign us_tick     = (presc == PRESC_LAST);
  assign frame_start = us_tick && (fcnt == FRAME_LAST);
  assign step_now    = (state_q == SLEW) && frame_start && (scnt_q == SCNT_LAST);
  assign settled     = (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      fcnt  <= '0;
    end else if (us_tick) begin
      presc <= '0;
      fcnt  <= (fcnt == FRAME_LAST) ? 16'd0 : fcnt + 16'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Widths only change on the frame boundary, so a pulse is never cut or stretched mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_base <= 16'(MIN_US);
      width_arm  <= 16'(MIN_US);
      pwm_base   <= 1'b0;
      pwm_arm    <= 1'b0;
    end else begin
      if (frame_start) begin
        width_base <= width_of(cur_base);
        width_arm  <= width_of(cur_arm);
      end
      pwm_base <= (fcnt < width_base);
      pwm_arm  <= (fcnt < width_arm);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scnt_q     <= '0;
      tgt_base_q <= '0;
      tgt_arm_q  <= '0;
      cur_base   <= '0;
      cur_arm    <= '0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      tgt_base_q <= tgt_base_d;
      tgt_arm_q  <= tgt_arm_d;
      cur_base   <= cur_base_d;
      cur_arm    <= cur_arm_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    tgt_base_d = tgt_base_q;
    tgt_arm_d  = tgt_arm_q;
    cur_base_d = cur_base;
    cur_arm_d  = cur_arm;

    if ((state_q == SLEW) && frame_start) scnt_d = step_now ? '0 : scnt_q + SW'(1);

    // A step always uses the targets held before this cycle; a coincident load lands afterwards.
    if (step_now) begin
      cur_base_d = toward(cur_base, tgt_base_q);
      cur_arm_d  = toward(cur_arm, tgt_arm_q);
    end

    if (load) begin
      tgt_base_d = clamp_deg(tgt_base);
      tgt_arm_d  = clamp_deg(tgt_arm);
    end

    case (state_q)
      IDLE: if ((tgt_base_d != cur_base_d) || (tgt_arm_d != cur_arm_d)) state_d = SLEW;
      SLEW: if ((tgt_base_d == cur_base_d) && (tgt_arm_d == cur_arm_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_servo_slew_driver.sv
// Bench for servo_slew_driver: three instances (full-scale timing, fast frames,
// four frames per step) driven by independent processes sharing one clock.
module tb_servo_slew_driver;

  localparam int D_PERIOD = 3000;
  localparam int F_PERIOD = 192;
  localparam int F_MIN    = 8;
  localparam int S_PERIOD = 64;

  typedef struct {
    logic [7:0] tb;
    logic [7:0] ta;
    logic [7:0] eb;
    logic [7:0] ea;
    logic       settle_next;
  } load_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst, d_load, d_pb, d_pa, d_st;
  logic [7:0] d_tb, d_ta, d_cb, d_ca;
  logic       f_rst, f_load, f_pb, f_pa, f_st;
  logic [7:0] f_tb, f_ta, f_cb, f_ca;
  logic       s_rst, s_load, s_pb, s_pa, s_st;
  logic [7:0] s_tb, s_ta, s_cb, s_ca;

  servo_slew_driver #(.TICKS_PER_US(1), .PERIOD_US(D_PERIOD)) u_d (
    .clk(clk), .rst(d_rst), .load(d_load), .tgt_base(d_tb), .tgt_arm(d_ta),
    .pwm_base(d_pb), .pwm_arm(d_pa), .cur_base(d_cb), .cur_arm(d_ca), .settled(d_st));

  servo_slew_driver #(.TICKS_PER_US(1), .PERIOD_US(F_PERIOD), .MIN_US(F_MIN),
                      .US_PER_DEG(1), .STEP_FRAMES(1)) u_f (
    .clk(clk), .rst(f_rst), .load(f_load), .tgt_base(f_tb), .tgt_arm(f_ta),
    .pwm_base(f_pb), .pwm_arm(f_pa), .cur_base(f_cb), .cur_arm(f_ca), .settled(f_st));

  servo_slew_driver #(.TICKS_PER_US(1), .PERIOD_US(S_PERIOD), .MIN_US(F_MIN),
                      .US_PER_DEG(1), .STEP_FRAMES(4)) u_s (
    .clk(clk), .rst(s_rst), .load(s_load), .tgt_base(s_tb), .tgt_arm(s_ta),
    .pwm_base(s_pb), .pwm_arm(s_pa), .cur_base(s_cb), .cur_arm(s_ca), .settled(s_st));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_deg(input int v);
    return (v > 180) ? 180 : v;
  endfunction

  function automatic int step_to(input int c, input int t);
    if (c < t) return c + 1;
    if (c > t) return c - 1;
    return c;
  endfunction

  // Length of the next complete high pulse on the fast instance's base output.
  task automatic f_pulse(output int w);
    int budget;
    budget = 3 * F_PERIOD;
    w = 0;
    while (f_pb !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
    while (f_pb !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    while (f_pb === 1'b1 && budget > 0) begin @(negedge clk); w++; budget--; end
    if (budget == 0) w = -1;
  endtask

  task automatic run_d();
    int hb, ha, bad, fs, eb, ea;
    d_rst = 1'b1; d_load = 1'b0; d_tb = '0; d_ta = '0;
    repeat (2) @(negedge clk);
    check("d_reset_pwm", {d_pb, d_pa}, 2'b00);
    check("d_reset_cur", {d_cb, d_ca}, 16'h0000);
    check("d_reset_settled", d_st, 1'b1);
    d_rst = 1'b0;
    hb = 0; ha = 0; bad = 0;
    for (int n = 1; n <= 2 * D_PERIOD; n++) begin
      @(negedge clk);
      hb += d_pb; ha += d_pa;
      if (d_st !== 1'b1 || d_cb !== 8'd0 || d_ca !== 8'd0) bad++;
      if (n == D_PERIOD) begin
        check("d_frame1_base_high", hb, 500);
        check("d_frame1_arm_high", ha, 500);
        hb = 0; ha = 0;
      end
    end
    check("d_frame2_base_high", hb, 500);
    check("d_frame2_arm_high", ha, 500);
    check("d_idle_trace_bad", bad, 0);

    d_tb = 8'd10; d_ta = 8'd3; d_load = 1'b1;
    hb = 0; ha = 0; bad = 0;
    for (int n = 2 * D_PERIOD + 1; n <= 14 * D_PERIOD; n++) begin
      @(negedge clk);
      d_load = 1'b0;
      fs = n / D_PERIOD - 2;
      eb = (fs < 10) ? fs : 10;
      ea = (fs < 3) ? fs : 3;
      if (d_cb !== eb[7:0] || d_ca !== ea[7:0] || d_st !== (fs >= 10)) bad++;
      if (n == 2 * D_PERIOD + 1) check("d_settled_drops_after_load", d_st, 1'b0);
      if (n == 5 * D_PERIOD) check("d_arm_reaches_3", d_ca, 3);
      if (n == 12 * D_PERIOD - 1) check("d_before_tenth_step", {d_st, d_cb}, {1'b0, 8'd9});
      if (n == 12 * D_PERIOD) check("d_after_tenth_step", {d_st, d_cb, d_ca}, {1'b1, 8'd10, 8'd3});
      if (n > 13 * D_PERIOD) begin hb += d_pb; ha += d_pa; end
    end
    check("d_slew_trace_bad", bad, 0);
    check("d_final_base_pulse", hb, 610);
    check("d_final_arm_pulse", ha, 533);
  endtask

  task automatic run_f();
    load_vec_t vecs[5];
    int bad, budget, prev_b, prev_a, w, n, mb, ma, mtb, mta, wb, wa, nb, na;
    logic ld, epb, epa;
    int seq[$];

    vecs[0] = '{8'd255, 8'd200, 8'd180, 8'd180, 1'b0};
    vecs[1] = '{8'd175, 8'd181, 8'd175, 8'd180, 1'b0};
    vecs[2] = '{8'd178, 8'd180, 8'd178, 8'd180, 1'b0};
    vecs[3] = '{8'd178, 8'd180, 8'd178, 8'd180, 1'b1};
    vecs[4] = '{8'd181, 8'd179, 8'd180, 8'd179, 1'b0};

    f_rst = 1'b1; f_load = 1'b0; f_tb = '0; f_ta = '0;
    repeat (2) @(negedge clk);
    f_rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      f_tb = vecs[k].tb; f_ta = vecs[k].ta; f_load = 1'b1;
      @(negedge clk);
      f_load = 1'b0;
      check($sformatf("f_vec%0d_settled_next", k), f_st, vecs[k].settle_next);
      prev_b = f_cb; prev_a = f_ca; bad = 0;
      budget = 200 * F_PERIOD;
      while (f_st !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
        if (f_cb > 8'd180 || f_ca > 8'd180) bad++;
        if (int'(f_cb) - prev_b > 1 || prev_b - int'(f_cb) > 1) bad++;
        if (int'(f_ca) - prev_a > 1 || prev_a - int'(f_ca) > 1) bad++;
        prev_b = f_cb; prev_a = f_ca;
      end
      check($sformatf("f_vec%0d_converged", k), budget > 0, 1'b1);
      check($sformatf("f_vec%0d_final_cur", k), {f_cb, f_ca}, {vecs[k].eb, vecs[k].ea});
      check($sformatf("f_vec%0d_range_step_bad", k), bad, 0);
      if (k == 0) begin
        f_pulse(w);
        f_pulse(w);
        check("f_pulse_at_180", w, F_MIN + 180);
      end
    end

    // rst wins over a simultaneous load.
    f_rst = 1'b1; f_load = 1'b1; f_tb = 8'd99; f_ta = 8'd99;
    @(negedge clk);
    check("f_rst_beats_load", {f_st, f_cb, f_ca, f_pb}, {1'b1, 16'h0000, 1'b0});
    f_rst = 1'b0; f_load = 1'b0;
    repeat (3) @(negedge clk);
    check("f_idle_after_rst_load", {f_st, f_cb}, {1'b1, 8'd0});

    // Retarget while slewing.
    f_tb = 8'd20; f_ta = 8'd0; f_load = 1'b1;
    @(negedge clk);
    f_load = 1'b0;
    budget = 7 * F_PERIOD;
    while (f_cb !== 8'd5 && budget > 0) begin @(negedge clk); budget--; end
    check("f_retarget_reach_5", f_cb, 5);
    f_tb = 8'd2; f_load = 1'b1;
    @(negedge clk);
    f_load = 1'b0;
    check("f_retarget_cur_kept", {f_cb, f_st}, {8'd5, 1'b0});
    prev_b = f_cb;
    budget = 6 * F_PERIOD;
    while (f_st !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (int'(f_cb) != prev_b) seq.push_back(int'(f_cb));
      prev_b = f_cb;
    end
    check("f_retarget_num_steps", seq.size(), 3);
    if (seq.size() == 3) begin
      check("f_retarget_seq0", seq[0], 4);
      check("f_retarget_seq1", seq[1], 3);
      check("f_retarget_seq2", seq[2], 2);
    end
    check("f_retarget_final", {f_st, f_cb}, {1'b1, 8'd2});

    // Reset in the middle of a high pulse at cur=50.
    f_tb = 8'd50; f_load = 1'b1;
    @(negedge clk);
    f_load = 1'b0;
    budget = 52 * F_PERIOD;
    while (f_cb !== 8'd50 && budget > 0) begin @(negedge clk); budget--; end
    check("f_reach_50", f_cb, 50);
    budget = F_PERIOD;
    while (f_pb !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    check("f_pulse_high_before_rst", f_pb, 1'b1);
    f_rst = 1'b1; f_load = 1'b1; f_tb = 8'd7;
    @(negedge clk);
    check("f_midframe_rst", {f_pb, f_pa, f_cb, f_ca, f_st}, {2'b00, 16'h0000, 1'b1});
    f_rst = 1'b0; f_load = 1'b0;
    w = 0;
    for (int c = 0; c < F_PERIOD; c++) begin
      @(negedge clk);
      w += f_pb;
    end
    check("f_first_pulse_after_rst", w, F_MIN);
    check("f_settled_after_rst", {f_st, f_cb}, {1'b1, 8'd0});

    // Random loads against a frame-level model, including loads on step cycles.
    f_rst = 1'b1;
    @(negedge clk);
    f_rst = 1'b0;
    n = 0; mb = 0; ma = 0; mtb = 0; mta = 0; wb = F_MIN; wa = F_MIN;
    for (int c = 0; c < 40 * F_PERIOD; c++) begin
      if ((n + 1) % F_PERIOD == 0) ld = ($urandom_range(0, 1) == 1);
      else ld = ($urandom_range(0, 149) == 0);
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      na = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      f_load = ld; f_tb = nb[7:0]; f_ta = na[7:0];
      n++;
      epb = ((n - 1) % F_PERIOD) < wb;
      epa = ((n - 1) % F_PERIOD) < wa;
      if (n % F_PERIOD == 0) begin
        wb = F_MIN + mb;
        wa = F_MIN + ma;
        mb = step_to(mb, mtb);
        ma = step_to(ma, mta);
      end
      if (ld) begin
        mtb = clamp_deg(nb);
        mta = clamp_deg(na);
      end
      @(negedge clk);
      check("f_random", {f_pb, f_pa, f_cb, f_ca, f_st},
            {epb, epa, mb[7:0], ma[7:0], (mb == mtb && ma == mta)});
    end
    f_load = 1'b0;
  endtask

  task automatic run_s();
    int bad, fs, ea;
    s_rst = 1'b1; s_load = 1'b0; s_tb = '0; s_ta = '0;
    @(negedge clk);
    s_rst = 1'b0;
    repeat (10) @(negedge clk);
    s_ta = 8'd2; s_load = 1'b1; bad = 0;
    for (int n = 11; n <= 10 * S_PERIOD; n++) begin
      @(negedge clk);
      s_load = 1'b0;
      fs = n / S_PERIOD;
      ea = (fs / 4 < 2) ? fs / 4 : 2;
      if (s_ca !== ea[7:0] || s_cb !== 8'd0 || s_st !== (ea == 2)) bad++;
      if (n == 11) check("s_settled_drops", s_st, 1'b0);
      if (n == 4 * S_PERIOD - 1) check("s_hold_before_4th", s_ca, 0);
      if (n == 4 * S_PERIOD) check("s_step_at_4th", s_ca, 1);
      if (n == 8 * S_PERIOD - 1) check("s_before_8th", {s_st, s_ca}, {1'b0, 8'd1});
      if (n == 8 * S_PERIOD) check("s_settled_at_8th", {s_st, s_ca}, {1'b1, 8'd2});
    end
    check("s_trace_bad", bad, 0);
  endtask

  initial begin
    fork
      run_d();
      run_f();
      run_s();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
